// File: rtl/ov_fifo_reader_pkg.sv
// Shared constants for the OV7670 + AL422 FIFO reader: default frame
// geometry, read-pointer reset length and FSM state encodings.
package ov_fifo_reader_pkg;

   localparam int OV_H_PIX_DEF    = 640;
   localparam int OV_V_LINES_DEF  = 480;
   localparam int OV_RRST_CYC_DEF = 4;

   typedef logic [2:0] ov_state_t;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WAIT_VS = 3'd1;
   localparam logic [2:0] ST_WRITE   = 3'd2;
   localparam logic [2:0] ST_RRST    = 3'd3;
   localparam logic [2:0] ST_READ    = 3'd4;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level plus a rising-edge
// detector on the synchronized copy.
module sync_edge_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Synchronize, then keep one delayed copy for edge detection
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/ov_fifo_reader.sv
// Captures one camera frame into the AL422 FIFO between two vsync rises,
// then reads it back as RGB565 pixels with a ready/valid handshake.
module ov_fifo_reader
   import ov_fifo_reader_pkg::*;
#(
   parameter int H_PIX    = OV_H_PIX_DEF,
   parameter int V_LINES  = OV_V_LINES_DEF,
   parameter int RRST_CYC = OV_RRST_CYC_DEF
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        cfg_done,
   input  logic        OV_vsync,
   input  logic [7:0]  OV_data,
   output logic        OV_wrst,
   output logic        OV_wen,
   output logic        OV_rrst,
   output logic        OV_oe,
   output logic        OV_rclk,
   output logic [15:0] pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        frame_start,
   output logic        frame_done
);

   localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
   localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
   localparam int CW = (RRST_CYC > 1) ? $clog2(RRST_CYC) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_PIX - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);
   localparam logic [CW-1:0] C_LAST = CW'(RRST_CYC - 1);

   ov_state_t     r_state;
   ov_state_t     w_nxt;
   logic          r_wrst;
   logic          r_wen;
   logic          r_rrst;
   logic          r_oe;
   logic          r_rclk;
   logic [CW-1:0] r_cnt;
   logic          r_byte;
   logic [7:0]    r_hi;
   logic [15:0]   r_pdata;
   logic          r_valid;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;

   logic w_rise;
   logic w_xfer;
   logic w_stall;
   logic w_last;
   logic w_first;
   logic w_capture;

   sync_edge_det u_vs_sync (
      .i_clk   (sys_clk),
      .i_rst   (rst),
      .i_async (OV_vsync),
      .o_rise  (w_rise)
   );

   assign w_xfer    = r_valid & pix_ready;
   assign w_stall   = r_valid & ~pix_ready;
   assign w_last    = (r_x == X_LAST) && (r_y == Y_LAST);
   assign w_first   = (r_x == '0) && (r_y == '0);
   // Byte is sampled on the edge that drives rclk 1->0 (data settled
   // after the FIFO's rising rclk).  rclk is never 1 while a pixel is
   // pending, so a capture can never overwrite an unaccepted pixel.
   assign w_capture = (r_state == ST_READ) && r_rclk;

   // Next-state decode; vsync is only looked at in WAIT_VS and WRITE
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (cfg_done)           w_nxt = ST_WAIT_VS;
         ST_WAIT_VS: if (w_rise)             w_nxt = ST_WRITE;
         ST_WRITE:   if (w_rise)             w_nxt = ST_RRST;
         ST_RRST:    if (r_cnt == C_LAST)    w_nxt = ST_READ;
         ST_READ:    if (w_xfer && w_last)   w_nxt = ST_WAIT_VS;
         default:                            w_nxt = ST_IDLE;
      endcase
   end

   // State and FIFO control pins, registered from next state so each pin
   // changes in the same cycle as the state
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_wrst  <= 1'b1;
         r_wen   <= 1'b0;
         r_rrst  <= 1'b1;
         r_oe    <= 1'b1;
         r_rclk  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nxt;
         r_wrst  <= ~((r_state == ST_WAIT_VS) && (w_nxt == ST_WRITE));
         r_wen   <= (w_nxt == ST_WRITE);
         r_rrst  <= (w_nxt != ST_RRST);
         r_oe    <= (w_nxt != ST_READ);
         r_cnt   <= ((r_state == ST_RRST) && (w_nxt == ST_RRST)) ? r_cnt + 1'b1 : '0;
         if ((r_state == ST_RRST) && (w_nxt == ST_RRST))
            r_rclk <= ~r_rclk;
         else if ((r_state == ST_READ) && (w_nxt == ST_READ) && !w_stall)
            r_rclk <= ~r_rclk;
         else
            r_rclk <= 1'b0;
      end
   end

   // Byte pairing, pixel handshake and frame position counters
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_byte  <= 1'b0;
         r_hi    <= '0;
         r_pdata <= '0;
         r_valid <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
      end else if (r_state != ST_READ) begin
         r_byte  <= 1'b0;
         r_valid <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
      end else begin
         if (w_capture) begin
            r_byte <= ~r_byte;
            if (!r_byte) begin
               r_hi <= OV_data;
            end else begin
               r_pdata <= {r_hi, OV_data};
               r_valid <= 1'b1;
            end
         end
         if (w_xfer) begin
            r_valid <= 1'b0;
            if (r_x == X_LAST) begin
               r_x <= '0;
               r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
               r_x <= r_x + 1'b1;
            end
         end
      end
   end

   assign OV_wrst     = r_wrst;
   assign OV_wen      = r_wen;
   assign OV_rrst     = r_rrst;
   assign OV_oe       = r_oe;
   assign OV_rclk     = r_rclk;
   assign pix_data    = r_pdata;
   assign pix_valid   = r_valid;
   // Frame markers qualify the actual transfer; suppressed during reset so
   // a reset landing on a transfer cycle never reports a frame edge
   assign frame_start = w_xfer & w_first & ~rst;
   assign frame_done  = w_xfer & w_last & ~rst;

endmodule

// File: tb/tb_ov_fifo_reader.sv
// Directed bench for ov_fifo_reader with a 4x2 frame and an AL422 model.
module tb_ov_fifo_reader;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_done = 1'b0;
   logic        OV_vsync = 1'b0;
   logic [7:0]  OV_data = 8'h00;
   logic        pix_ready = 1'b0;
   logic        OV_wrst, OV_wen, OV_rrst, OV_oe, OV_rclk;
   logic [15:0] pix_data;
   logic        pix_valid, frame_start, frame_done;

   ov_fifo_reader #(.H_PIX(4), .V_LINES(2), .RRST_CYC(4)) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .cfg_done    (cfg_done),
      .OV_vsync    (OV_vsync),
      .OV_data     (OV_data),
      .OV_wrst     (OV_wrst),
      .OV_wen      (OV_wen),
      .OV_rrst     (OV_rrst),
      .OV_oe       (OV_oe),
      .OV_rclk     (OV_rclk),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .frame_start (frame_start),
      .frame_done  (frame_done)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // FIFO contents: 12 34 56 78 ... (step 0x22); pixels hand-paired below
   logic [7:0]  mem [16] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'h00,
                             8'h22, 8'h44, 8'h66, 8'h88, 8'hAA, 8'hCC, 8'hEE, 8'h10};
   logic [15:0] exp_pix [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDE00,
                                16'h2244, 16'h6688, 16'hAACC, 16'hEE10};
   int rptr = 0;

   // AL422 read port: pointer reset when rrst low on rclk rise, else output next byte
   always @(posedge OV_rclk) begin
      if (!OV_rrst) rptr = 0;
      else begin
         OV_data = mem[rptr & 15];
         rptr++;
      end
   end

   int cyc = 0, n_x = 0, xfer_cnt = 0, done_cnt = 0, start_cnt = 0;
   int wen_cnt = 0, wrst_lo = 0, rrst_lo = 0, stall_cnt = 0, t_first = 0, t_last = 0;
   logic        stalled = 1'b0;
   logic [15:0] prev_d = 16'h0;

   // Monitor: counts pin activity and checks every pixel transfer
   always @(negedge sys_clk) begin
      cyc++;
      if (rst) begin
         n_x = 0;
         stalled = 1'b0;
      end else begin
         if (OV_wen)   wen_cnt++;
         if (!OV_wrst) wrst_lo++;
         if (!OV_rrst) rrst_lo++;
         if (stalled) begin
            chk("stall_data", pix_data, prev_d);
            chk("stall_rclk", OV_rclk, 0);
         end
         stalled = pix_valid && !pix_ready;
         if (stalled) stall_cnt++;
         prev_d = pix_data;
         if (frame_done)  done_cnt++;
         if (frame_start) start_cnt++;
         if (pix_valid && pix_ready) begin
            chk("pix", pix_data, exp_pix[n_x & 7]);
            chk("fstart", frame_start, n_x == 0);
            chk("fdone", frame_done, n_x == 7);
            if (n_x == 0) t_first = cyc;
            if (n_x == 7) t_last = cyc;
            xfer_cnt++;
            n_x = (n_x == 7) ? 0 : n_x + 1;
         end
      end
   end

   task automatic tick(input int k);
      repeat (k) @(posedge sys_clk);
      #2;
   endtask

   task automatic vs_pulse(input int hi, input int lo);
      OV_vsync = 1'b1; tick(hi);
      OV_vsync = 1'b0; tick(lo);
   endtask

   task automatic wait_xfer(input string tag, input int tgt, input int budget);
      int b = 0;
      while (xfer_cnt < tgt && b < budget) begin tick(1); b++; end
      chk(tag, xfer_cnt, tgt);
   endtask

   // Two vsync rises 10 cycles apart, then wait for the read phase
   task automatic start_frame();
      int w0 = wen_cnt, s0 = wrst_lo, r0 = rrst_lo, b = 0;
      tick(3);
      vs_pulse(3, 7);
      vs_pulse(3, 2);
      while (OV_oe && b < 60) begin tick(1); b++; end
      chk("read_entry", OV_oe, 0);
      chk("wen_cycles", wen_cnt - w0, 10);
      chk("wrst_low", wrst_lo - s0, 1);
      chk("rrst_low", rrst_lo - r0, 4);
   endtask

   task automatic chk_reset_outs();
      @(negedge sys_clk);
      chk("rst_wrst", OV_wrst, 1);
      chk("rst_wen", OV_wen, 0);
      chk("rst_rrst", OV_rrst, 1);
      chk("rst_oe", OV_oe, 1);
      chk("rst_rclk", OV_rclk, 0);
      chk("rst_valid", pix_valid, 0);
      chk("rst_data", pix_data, 0);
      chk("rst_fstart", frame_start, 0);
      chk("rst_fdone", frame_done, 0);
   endtask

   initial begin
      int x0, d0, s0, w1, st0;
      // reset state
      tick(3);
      chk_reset_outs();
      @(posedge sys_clk); #2;
      rst = 1'b0;

      // no configuration: vsync must be ignored
      x0 = xfer_cnt; w1 = wen_cnt;
      vs_pulse(3, 5); vs_pulse(3, 5);
      chk("nocfg_wen", wen_cnt - w1, 0);
      chk("nocfg_xfer", xfer_cnt - x0, 0);
      chk("nocfg_oe", OV_oe, 1);

      // full frame, ready held high
      cfg_done = 1'b1; pix_ready = 1'b1;
      x0 = xfer_cnt; d0 = done_cnt; s0 = start_cnt;
      start_frame();
      wait_xfer("frame1", x0 + 8, 120);
      chk("frame1_done", done_cnt - d0, 1);
      chk("frame1_start", start_cnt - s0, 1);
      chk("thruput", t_last - t_first, 28);

      // backpressure for 10 cycles after two pixels
      x0 = xfer_cnt; d0 = done_cnt; st0 = stall_cnt;
      start_frame();
      wait_xfer("pre_stall", x0 + 2, 40);
      pix_ready = 1'b0; tick(10); pix_ready = 1'b1;
      wait_xfer("stall_frame", x0 + 8, 120);
      chk("stall_cycles", stall_cnt - st0, 7);
      chk("stall_done", done_cnt - d0, 1);

      // vsync during read is ignored
      x0 = xfer_cnt; d0 = done_cnt;
      start_frame();
      w1 = wen_cnt;
      tick(2);
      vs_pulse(3, 3);
      wait_xfer("vs_read_frame", x0 + 8, 120);
      chk("vs_read_wen", wen_cnt - w1, 0);
      chk("vs_read_done", done_cnt - d0, 1);

      // reset after three pixels, then a clean restart
      x0 = xfer_cnt; d0 = done_cnt;
      start_frame();
      wait_xfer("pre_rst", x0 + 3, 60);
      rst = 1'b1;
      @(posedge sys_clk);
      chk_reset_outs();
      chk("rst_no_done", done_cnt - d0, 0);
      @(posedge sys_clk); #2;
      rst = 1'b0;
      x0 = xfer_cnt; d0 = done_cnt; s0 = start_cnt;
      start_frame();
      wait_xfer("restart_frame", x0 + 8, 120);
      chk("restart_done", done_cnt - d0, 1);
      chk("restart_start", start_cnt - s0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ov_fifo_reader.md
OV_FIFO_READER -- requirements
Module: ov_fifo_reader

Interface
REQ-001 SHALL have parameter H_PIX, default 640, pixels per line.
REQ-002 SHALL have parameter V_LINES, default 480, lines per frame.
REQ-003 SHALL have parameter RRST_CYC, default 4, sys_clk cycles OV_rrst is held low.
REQ-004 sys_clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cfg_done  in  1  SCCB register load complete; level.
REQ-007 OV_vsync  in  1  camera frame sync, asynchronous to sys_clk.
REQ-008 OV_data  in  8  AL422 FIFO read data.
REQ-009 OV_wrst  out  1  FIFO write-pointer reset, active low.
REQ-010 OV_wen  out  1  FIFO write enable, active high.
REQ-011 OV_rrst  out  1  FIFO read-pointer reset, active low.
REQ-012 OV_oe  out  1  FIFO output enable, active low.
REQ-013 OV_rclk  out  1  FIFO read clock, generated from sys_clk.
REQ-014 pix_data  out  16  RGB565 pixel to SDRAM write buffer.
REQ-015 pix_valid  out  1  pix_data valid.
REQ-016 pix_ready  in  1  downstream accepts; transfer when pix_valid and pix_ready are both high.
REQ-017 frame_start  out  1  one-cycle pulse on first pixel of a frame.
REQ-018 frame_done  out  1  one-cycle pulse on last pixel transfer of a frame.

Function
REQ-019 OV_vsync SHALL pass a 2-flop synchronizer; a rising edge is detected on the synchronized signal (3-cycle latency max).
REQ-020 FSM states SHALL be IDLE, WAIT_VS, WRITE, RRST, READ.
REQ-021 IDLE -> WAIT_VS when cfg_done=1.
REQ-022 WAIT_VS -> WRITE on vsync rise; OV_wrst SHALL pulse low for exactly 1 cycle on entry; OV_wen SHALL be 1 throughout WRITE.
REQ-023 WRITE -> RRST on next vsync rise; OV_wen SHALL go 0 in the same cycle the state changes.
REQ-024 RRST: OV_rrst low for RRST_CYC cycles while OV_rclk toggles every cycle; then -> READ with OV_rrst high.
REQ-025 READ: OV_oe=0; OV_rclk toggles each sys_clk cycle; OV_data SHALL be sampled in the cycle OV_rclk is driven 1->0.
REQ-026 First sampled byte of a pair SHALL go to pix_data[15:8], second to pix_data[7:0]; pix_valid asserts the cycle after the second byte.
REQ-027 While pix_valid=1 and pix_ready=0, OV_rclk SHALL hold at 0 and pix_data SHALL be stable.
REQ-028 Pixel counter wraps at H_PIX-1 and increments the line counter; pixel (H_PIX-1, V_LINES-1) accepted SHALL pulse frame_done and -> WAIT_VS.
REQ-029 frame_start SHALL pulse with the transfer of pixel (0,0).
REQ-030 vsync rises during RRST or READ SHALL be ignored; OV_wen stays 0 so the FIFO is not overwritten.
REQ-031 cfg_done dropping SHALL only be checked in IDLE.
REQ-032 Throughput: 1 pixel per 4 sys_clk cycles with pix_ready=1.

Reset
REQ-033 On rst: state IDLE; counters 0; OV_wrst=1, OV_wen=0, OV_rrst=1, OV_oe=1, OV_rclk=0, pix_valid=0, pix_data=0, frame_start=0, frame_done=0.
REQ-034 rst mid-READ SHALL drop pix_valid the next cycle with no frame_done; a frame in progress is discarded.

Structure
REQ-035 State encodings and default H_PIX/V_LINES SHALL live in a shared package/include alongside the SDRAM parameter file.
REQ-036 The vsync synchronizer + edge detector SHALL be a sub-module named sync_edge_det.

Verification
REQ-037 H_PIX=4, V_LINES=2, cfg_done=1, two vsync pulses -> OV_wrst one low cycle, OV_wen high between pulses, then OV_rrst low 4 cycles.
REQ-038 READ with OV_data sequence 0x12,0x34,... and pix_ready=1 -> pix_data 0x1234 first; 8 transfers; frame_done on the 8th only.
REQ-039 pix_ready=0 for 10 cycles mid-line -> OV_rclk held 0, pix_data unchanged, no byte lost or duplicated.
REQ-040 vsync pulse during READ -> ignored, OV_wen stays 0, frame completes with 8 pixels.
REQ-041 rst asserted after 3 pixels -> all outputs at reset values next cycle; after release and cfg_done, frame restarts at pixel (0,0) with frame_start.
REQ-042 cfg_done=0 with vsync toggling -> FSM stays IDLE, OV_wen=0, no pix_valid.
